// File: rtl/ram_pkg.sv
// Shared types and helpers for the two-port register-file RAM.
// Byte-lane merge is used by both the write path and the RAM_BYPASS_EN read bypass.
package ram_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam int MAXW = 1024;
  localparam int MAXB = MAXW / 8;

  function automatic int lanes(input int w);
    return w / 8;
  endfunction

  function automatic logic [MAXW-1:0] merge(
    input logic [MAXW-1:0] od,
    input logic [MAXW-1:0] nd,
    input logic [MAXB-1:0] be
  );
    logic [MAXW-1:0] r;
    r = od;
    for (int i = 0; i < MAXB; i++)
      if (be[i]) r[8*i +: 8] = nd[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then idles.
// Busy is registered; the clear write is suppressed while Reset is held.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          busy,
  output logic [AW-1:0] clr_addr,
  output logic          clr_we
);

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          if (cnt == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        IDLE: busy <= 1'b0;
      endcase
    end
  end

  assign clr_addr = cnt;
  assign clr_we   = busy & ~Reset;

endmodule

// File: rtl/ram_2p_param.sv
// Parametrised 1W/1R register-file RAM with byte masking and clear-on-reset.
// Define RAM_BYPASS_EN for write-first same-address reads; default is read-first.
module ram_2p_param
  import ram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [AW-1:0]            InSel,
  input  logic                     InEn,
  input  logic [lanes(WIDTH)-1:0]  InBe,
  input  logic [WIDTH-1:0]         In,
  input  logic [AW-1:0]            OutSel,
  input  logic                     OutEn,
  output logic [WIDTH-1:0]         Out,
  output logic                     OutValid,
  output logic                     Busy
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          busy;
  logic [AW-1:0] clr_addr;
  logic          clr_we;

  ram_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .Clk      (Clk),
    .Reset    (Reset),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign Busy = busy;

  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;

  assign wr_ok = InEn & ~busy & ~Reset
               & (int'(InSel) < DEPTH);
  assign rd_ok = int'(OutSel) < DEPTH;

  assign wr_word = WIDTH'(merge(
    MAXW'(mem[InSel]), MAXW'(In), MAXB'(InBe)));

`ifdef RAM_BYPASS_EN
  logic             hit;
  logic [WIDTH-1:0] byp_word;

  assign hit      = wr_ok & (InSel == OutSel);
  assign byp_word = WIDTH'(merge(
    MAXW'(mem[OutSel]), MAXW'(In), MAXB'(InBe)));
  assign rd_word  = hit ? byp_word : mem[OutSel];
`else
  assign rd_word = mem[OutSel];
`endif

  // Clear writes own the port while busy; user writes only in IDLE.
  always_ff @(posedge Clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (wr_ok)
      mem[InSel] <= wr_word;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out      <= '0;
      OutValid <= 1'b0;
    end else if (busy) begin
      Out      <= '0;
      OutValid <= 1'b0;
    end else if (OutEn) begin
      Out      <= rd_ok ? rd_word : '0;
      OutValid <= 1'b1;
    end else begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_2p_param.sv
// Directed bench for ram_2p_param: clear, readback, masking, RDW, non-pow2.
// Honours RAM_BYPASS_EN for the read-during-write expectation.
module tb_ram_2p_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wsel, rsel;
  logic        wen, ren;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] q;
  logic        qv, busy;

  logic [7:0]  wsel2, rsel2;
  logic        wen2, ren2;
  logic [3:0]  be2;
  logic [31:0] wd2;
  logic [31:0] q2;
  logic        qv2, busy2;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_2p_param #(.WIDTH(32), .DEPTH(256)) dut (
    .Clk(clk), .Reset(rst),
    .InSel(wsel), .InEn(wen), .InBe(be), .In(wd),
    .OutSel(rsel), .OutEn(ren),
    .Out(q), .OutValid(qv), .Busy(busy)
  );

  ram_2p_param #(.WIDTH(32), .DEPTH(200)) dut2 (
    .Clk(clk), .Reset(rst),
    .InSel(wsel2), .InEn(wen2), .InBe(be2), .In(wd2),
    .OutSel(rsel2), .OutEn(ren2),
    .Out(q2), .OutValid(qv2), .Busy(busy2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    wsel = a; wd = d; be = m; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [31:0] exp);
    rsel = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    check({tag, "_data"}, q, exp);
    check({tag, "_valid"}, 32'(qv), 32'd1);
  endtask

  logic [31:0] rdw_exp;
  int          n, n2;
  logic        vseen;

  initial begin
    rst = 1'b1; wen = 0; ren = 0; wsel = 0; rsel = 0; be = 0; wd = 0;
    wen2 = 0; ren2 = 0; wsel2 = 0; rsel2 = 0; be2 = 0; wd2 = 0;

    // reset clear
    repeat (3) tick();
    check("rst_out",   q,          32'h0);
    check("rst_valid", 32'(qv),    32'd0);
    check("rst_busy",  32'(busy),  32'd1);
    rst = 1'b0;
    n = 0; n2 = 0;
    do begin
      tick();
      n++;
      if (!busy2 && n2 == 0) n2 = n;
    end while (busy && n < 1000);
    check("busy_len",  n,  256);
    check("busy2_len", n2, 200);
    rd("clr0",   8'd0,   32'h0);
    rd("clr8",   8'd8,   32'h0);
    rd("clr255", 8'd255, 32'h0);

    // sequential write / readback
    for (int k = 0; k < 32; k++) wr(8'(8*k), 32'(2048*k), 4'hF);
    for (int k = 0; k < 32; k++) rd("seq", 8'(8*k), 32'(2048*k));

    // byte mask and zero-mask no-op
    wr(8'd5, 32'hAABBCCDD, 4'hF);
    wr(8'd5, 32'h11223344, 4'b0101);
    rd("mask", 8'd5, 32'hAA22CC44);
    wr(8'd5, 32'h55555555, 4'b0000);
    rd("be0", 8'd5, 32'hAA22CC44);

    // OutEn low: data holds, valid drops
    tick();
    check("hold_data",  q,       32'hAA22CC44);
    check("hold_valid", 32'(qv), 32'd0);

    // read during write
    wr(8'd16, 32'h00000001, 4'hF);
`ifdef RAM_BYPASS_EN
    rdw_exp = 32'hDEADBEEF;
`else
    rdw_exp = 32'h00000001;
`endif
    wsel = 8'd16; wd = 32'hDEADBEEF; be = 4'hF; wen = 1'b1;
    rd("rdw", 8'd16, rdw_exp);
    wen = 1'b0;
    rd("rdw_after", 8'd16, 32'hDEADBEEF);

    // reset mid-clear, requests ignored while busy
    wr(8'd3, 32'h12345678, 4'hF);
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    repeat (100) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    vseen = 1'b0;
    n = 0;
    wsel = 8'd3; wd = 32'hFFFFFFFF; be = 4'hF; wen = 1'b1;
    rsel = 8'd3; ren = 1'b1;
    do begin
      tick();
      n++;
      if (qv) vseen = 1'b1;
      if (n == 20) begin wen = 1'b0; ren = 1'b0; end
    end while (busy && n < 1000);
    wen = 1'b0; ren = 1'b0;
    check("reclr_len",  n,          256);
    check("busy_valid", 32'(vseen), 32'd0);
    rd("ign_wr", 8'd3, 32'h0);
    rd("reclr16", 8'd16, 32'h0);

    // non-power-of-two depth
    wsel2 = 8'd199; wd2 = 32'hCAFEF00D; be2 = 4'hF; wen2 = 1'b1;
    tick();
    wsel2 = 8'd210; wd2 = 32'h87654321;
    tick();
    wen2 = 1'b0;
    rsel2 = 8'd210; ren2 = 1'b1;
    tick();
    check("oor_data",  q2,       32'h0);
    check("oor_valid", 32'(qv2), 32'd1);
    rsel2 = 8'd199;
    tick();
    ren2 = 1'b0;
    check("top_data",  q2,       32'hCAFEF00D);
    check("top_valid", 32'(qv2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
